multi_channel_watchdog: RTL and testbench
=========================================

# multi_channel_watchdog

Parametrised, multi-channel successor to the single-channel watchdog timer in the AM radio FPGA control path. Each channel supervises one heartbeat source, such as the DSP/NCO pipeline or the host link. A channel raises an early warning after a configurable silence and trips after a configurable timeout. Trips are latched (or optionally auto-cleared), counted, and attributed, so the top level can mute the RF output and report which source failed first.

## Interface
Parameters:
- NUM_CH, 4, number of supervised channels (1..16)
- CNT_W, 32, per-channel counter width
- TIMEOUT, 50_000_000, cycles of heartbeat silence before trip
- WARN_AT, 37_500_000, cycles of silence before warning; elaboration error unless 0 < WARN_AT < TIMEOUT < 2**CNT_W
- AUTO_CLEAR, 0, 0 = trip latched until ack; 1 = heartbeat also clears a trip
- TC_W, 16, trip_count width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  NUM_CH  per-channel enable (level)
- heartbeat  in  NUM_CH  per-channel kick (level, sampled each cycle)
- force_trip  in  NUM_CH  force channel into TRIPPED (one-cycle pulse sufficient)
- ack  in  NUM_CH  clear a latched trip
- warning  out  NUM_CH  silence ≥ WARN_AT cycles, or tripped
- triggered  out  NUM_CH  channel tripped
- any_triggered  out  1  OR of triggered
- first_valid  out  1  first_id is valid
- first_id  out  max(1,$clog2(NUM_CH))  index of first channel to trip in current fault episode
- trip_count  out  TC_W  saturating count of trip events

## Operation
- Per-channel FSM has states DISABLED, RUNNING, WARN, TRIPPED, plus counter cnt[CNT_W].
- Priority per channel, highest first: rst, then enable=0, then force_trip, then ack/heartbeat, then counting.
- enable=0 from any state: go to DISABLED with cnt=0. This clears warning and triggered.
- DISABLED with enable=1: go to RUNNING with cnt=0. This edge counts as a heartbeat.
- RUNNING/WARN with heartbeat=1: go to RUNNING with cnt=0.
- RUNNING/WARN with no heartbeat: cnt increments.
  - Entering cnt==WARN_AT moves to WARN.
  - Entering cnt==TIMEOUT moves to TRIPPED.
  - cnt holds at TIMEOUT in TRIPPED and never wraps.
- force_trip=1 with enable=1: go to TRIPPED from any state on the next edge. It overrides a same-cycle heartbeat or ack.
- In TRIPPED:
  - ack=1 moves to RUNNING with cnt=0.
  - If AUTO_CLEAR=1, heartbeat=1 does the same.
  - Otherwise heartbeat is ignored.
- Outputs are registered, with no combinational path from any input:
  - warning = state∈{WARN,TRIPPED}
  - triggered = state==TRIPPED
  - any_triggered = |triggered
- A trip event is any channel's transition into TRIPPED from a non-TRIPPED state.
- trip_count increments by 1 in each cycle containing ≥1 trip event, regardless of how many channels trip. It saturates at 2**TC_W−1.
- first_id/first_valid:
  - When first_valid=0 and a trip event occurs, first_valid is set and first_id captures the lowest index among that cycle's trip events.
  - Both hold while any channel remains TRIPPED.
  - first_valid clears on the edge after which no channel is TRIPPED. If a new trip event occurs on that same edge, it re-captures.

## Timing
- Reset values: all FSMs DISABLED, cnt=0, warning=0, triggered=0, any_triggered=0, first_valid=0, first_id=0, trip_count=0.
- rst acts asynchronously and takes effect mid-count. Release is synchronised externally.
- Take edge N as the last edge with heartbeat=1, or the DISABLED→RUNNING edge, and assume no further heartbeat:
  - warning rises after edge N+WARN_AT.
  - triggered rises after edge N+TIMEOUT.
- A heartbeat sampled at edge N+TIMEOUT prevents the trip.
- force_trip sampled at edge M: triggered=1 after edge M.
  - trip_count and first_id update on the same edge M.
  - any_triggered and first_valid also update on edge M.
- ack sampled at edge M: triggered=0 after M and counting restarts from 0.
- Channels are fully independent. Simultaneous trips on several channels are a single trip_count increment.

## Test plan
Common configuration: NUM_CH=2, CNT_W=8, TIMEOUT=10, WARN_AT=6, AUTO_CLEAR=0, TC_W=4.

1. Release rst, enable=2'b01, no heartbeat -> warning[0]=1 after edge 6, triggered[0]=1 after edge 10, first_valid=1, first_id=0, trip_count=1. Channel 1 stays all-zero.
2. Heartbeat[0] pulsed every 9 cycles -> warning[0] toggles high at count 6 and drops on the kick, triggered never set. A kick exactly at count 10 -> no trip.
3. Both channels silent from the same edge -> both trip together, trip_count=1, first_id=0. ack both -> first_valid=0 one edge later.
4. Channel 1 trips first (force_trip[1]), channel 0 times out later -> first_id=1 retained, trip_count=2. With AUTO_CLEAR=0, heartbeat[1] does not clear. ack[1] plus force_trip[1] in the same cycle -> stays TRIPPED.
5. AUTO_CLEAR=1: after a trip, heartbeat[0] -> triggered[0]=0 next edge, cnt restarts, re-trips 10 cycles later, trip_count increments.
6. Assert rst at cnt=8 -> all outputs 0 immediately. Drop enable[0] while TRIPPED -> triggered[0]=0 next edge. 20 forced trips -> trip_count saturates at 15.

Source files
------------

// File: rtl/multi_channel_watchdog.sv
// Multi-channel heartbeat watchdog: per-channel silence counters with early warning,
// latched (or auto-cleared) trips, saturating trip counter and first-trip attribution.
module multi_channel_watchdog #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 50_000_000,
    parameter int WARN_AT    = 37_500_000,
    parameter int AUTO_CLEAR = 0,
    parameter int TC_W       = 16,
    localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] heartbeat,
    input  logic [NUM_CH-1:0] force_trip,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] triggered,
    output logic              any_triggered,
    output logic              first_valid,
    output logic [ID_W-1:0]   first_id,
    output logic [TC_W-1:0]   trip_count
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_WARN     = 2'd2,
        ST_TRIPPED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] WARN_CNT      = CNT_W'(WARN_AT);
    localparam bit               AUTO_CLEAR_EN = (AUTO_CLEAR != 0);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("multi_channel_watchdog: NUM_CH must be in 1..16");
    end
    if (!(WARN_AT > 0 && WARN_AT < TIMEOUT && 64'(TIMEOUT) < (64'd1 << CNT_W))) begin : g_bad_timing
        $error("multi_channel_watchdog: need 0 < WARN_AT < TIMEOUT < 2**CNT_W");
    end

    logic [NUM_CH-1:0] trip_event;
    logic [NUM_CH-1:0] tripped_next;
    logic [NUM_CH-1:0] warn_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

            assign cnt_inc = cnt_reg + CNT_W'(1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= ST_DISABLED;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Priority: enable low, then force_trip, then ack/heartbeat, then counting.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (!enable[gi]) begin
                    state_next = ST_DISABLED;
                    cnt_next   = '0;
                end else if (force_trip[gi]) begin
                    state_next = ST_TRIPPED;
                    cnt_next   = TIMEOUT_CNT;
                end else begin
                    case (state_reg)
                        ST_DISABLED: begin
                            state_next = ST_RUNNING;
                            cnt_next   = '0;
                        end
                        ST_RUNNING, ST_WARN: begin
                            if (heartbeat[gi]) begin
                                state_next = ST_RUNNING;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_inc;
                                if (cnt_inc == TIMEOUT_CNT) begin
                                    state_next = ST_TRIPPED;
                                end else if (cnt_inc == WARN_CNT) begin
                                    state_next = ST_WARN;
                                end
                            end
                        end
                        ST_TRIPPED: begin
                            if (ack[gi] || (AUTO_CLEAR_EN && heartbeat[gi])) begin
                                state_next = ST_RUNNING;
                                cnt_next   = '0;
                            end
                        end
                        default: begin
                            state_next = ST_DISABLED;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign tripped_next[gi] = (state_next == ST_TRIPPED);
            assign warn_next[gi]    = (state_next == ST_TRIPPED) || (state_next == ST_WARN);
            assign trip_event[gi]   = (state_next == ST_TRIPPED) && (state_reg != ST_TRIPPED);
        end
    endgenerate

    logic [NUM_CH-1:0] warning_reg;
    logic [NUM_CH-1:0] triggered_reg;
    logic              any_triggered_reg;
    logic              first_valid_reg, first_valid_next;
    logic [ID_W-1:0]   first_id_reg, first_id_next;
    logic [TC_W-1:0]   trip_count_reg, trip_count_next;
    logic [ID_W-1:0]   lowest_trip;
    logic              any_trip_event;
    logic              episode_continues;

    always_comb begin
        lowest_trip = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (trip_event[i]) begin
                lowest_trip = ID_W'(i);
            end
        end
    end

    assign any_trip_event = |trip_event;
    // The episode survives only if some channel tripped now is still tripped after this edge.
    assign episode_continues = |(triggered_reg & tripped_next);

    always_comb begin
        first_valid_next = first_valid_reg;
        first_id_next    = first_id_reg;
        trip_count_next  = trip_count_reg;
        if (any_trip_event && (!first_valid_reg || !episode_continues)) begin
            first_valid_next = 1'b1;
            first_id_next    = lowest_trip;
        end else if (!(|tripped_next)) begin
            first_valid_next = 1'b0;
        end
        if (any_trip_event && (trip_count_reg != {TC_W{1'b1}})) begin
            trip_count_next = trip_count_reg + TC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warning_reg       <= '0;
            triggered_reg     <= '0;
            any_triggered_reg <= 1'b0;
            first_valid_reg   <= 1'b0;
            first_id_reg      <= '0;
            trip_count_reg    <= '0;
        end else begin
            warning_reg       <= warn_next;
            triggered_reg     <= tripped_next;
            any_triggered_reg <= |tripped_next;
            first_valid_reg   <= first_valid_next;
            first_id_reg      <= first_id_next;
            trip_count_reg    <= trip_count_next;
        end
    end

    assign warning       = warning_reg;
    assign triggered     = triggered_reg;
    assign any_triggered = any_triggered_reg;
    assign first_valid   = first_valid_reg;
    assign first_id      = first_id_reg;
    assign trip_count    = trip_count_reg;

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Scoreboard bench for multi_channel_watchdog: two instances (latched and auto-clear trips),
// directed stimulus pushes hand-computed expectations, a negedge monitor compares them.
module tb_multi_channel_watchdog;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en, hb, ft, ack;
    logic [1:0] en_b, hb_b, ft_b, ack_b;
    logic [1:0] w_a, t_a, w_b, t_b;
    logic       any_a, any_b, fv_a, fv_b, fid_a, fid_b;
    logic [3:0] tc_a, tc_b;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_channel_watchdog #(
        .NUM_CH(2), .CNT_W(8), .TIMEOUT(10), .WARN_AT(6), .AUTO_CLEAR(0), .TC_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(en), .heartbeat(hb), .force_trip(ft), .ack(ack),
        .warning(w_a), .triggered(t_a), .any_triggered(any_a),
        .first_valid(fv_a), .first_id(fid_a), .trip_count(tc_a)
    );

    multi_channel_watchdog #(
        .NUM_CH(2), .CNT_W(8), .TIMEOUT(10), .WARN_AT(6), .AUTO_CLEAR(1), .TC_W(4)
    ) u_dut_ac (
        .clk(clk), .rst(rst), .enable(en_b), .heartbeat(hb_b), .force_trip(ft_b), .ack(ack_b),
        .warning(w_b), .triggered(t_b), .any_triggered(any_b),
        .first_valid(fv_b), .first_id(fid_b), .trip_count(tc_b)
    );

    typedef struct {
        int         due;
        bit         dut;
        string      name;
        logic [1:0] w;
        logic [1:0] t;
        logic       fv;
        logic       fid;
        logic       fid_care;
        logic [3:0] tc;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input bit d, input int k, input string nm, input logic [1:0] w,
                       input logic [1:0] t, input logic fv, input logic fid, input logic [3:0] tc);
        exp_t e;
        e.due = cyc + k; e.dut = d; e.name = nm; e.w = w; e.t = t;
        e.fv = fv; e.fid = fid; e.fid_care = fv; e.tc = tc;
        sb_q.push_back(e);
    endtask

    task automatic chk_rst(input bit d, input int k, input string nm);
        exp_t e;
        e.due = cyc + k; e.dut = d; e.name = nm; e.w = 2'b00; e.t = 2'b00;
        e.fv = 1'b0; e.fid = 1'b0; e.fid_care = 1'b1; e.tc = 4'd0;
        sb_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output sample is a candidate; compare all expectations that fall due.
    initial begin
        exp_t       e;
        logic [1:0] gw, gt;
        logic       gany, gfv, gfid, ok;
        logic [3:0] gtc;
        forever begin
            @(negedge clk);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                e = sb_q[i];
                if (e.due <= cyc) begin
                    if (e.dut) begin
                        gw = w_b; gt = t_b; gany = any_b; gfv = fv_b; gfid = fid_b; gtc = tc_b;
                    end else begin
                        gw = w_a; gt = t_a; gany = any_a; gfv = fv_a; gfid = fid_a; gtc = tc_a;
                    end
                    ok = (gw === e.w) && (gt === e.t) && (gany === (|e.t)) && (gfv === e.fv)
                         && (gtc === e.tc) && (!e.fid_care || (gfid === e.fid));
                    vectors++;
                    if (!ok) begin
                        miscompares++;
                        $display("FAIL %s dut%0d cyc=%0d: got w=%b t=%b any=%b fv=%b fid=%b tc=%0d, expected w=%b t=%b any=%b fv=%b fid=%b tc=%0d",
                                 e.name, e.dut, cyc, gw, gt, gany, gfv, gfid, gtc,
                                 e.w, e.t, |e.t, e.fv, e.fid, e.tc);
                    end else begin
                        $display("ok   %s dut%0d cyc=%0d: w=%b t=%b fv=%b fid=%b tc=%0d",
                                 e.name, e.dut, cyc, gw, gt, gfv, gfid, gtc);
                    end
                    sb_q.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        en = 2'b00; hb = 2'b00; ft = 2'b00; ack = 2'b00;
        en_b = 2'b00; hb_b = 2'b00; ft_b = 2'b00; ack_b = 2'b00;
        @(negedge clk);
        chk_rst(0, 1, "reset");
        chk_rst(1, 1, "reset_ac");
        @(negedge clk);
        rst = 1'b0;

        // 1: channel 0 enabled and silent
        en = 2'b01;
        chk(0, 6,  "t1_before_warn", 2'b00, 2'b00, 0, 0, 4'd0);
        chk(0, 7,  "t1_warn",        2'b01, 2'b00, 0, 0, 4'd0);
        chk(0, 10, "t1_before_trip", 2'b01, 2'b00, 0, 0, 4'd0);
        chk(0, 11, "t1_trip",        2'b01, 2'b01, 1, 0, 4'd1);
        wait_n(11);
        ack = 2'b01;
        chk(0, 1, "t1_ack", 2'b00, 2'b00, 0, 0, 4'd1);
        wait_n(1);
        ack = 2'b00;

        // 2: periodic kicks every 9 cycles, then a kick exactly at count 10
        for (int i = 0; i < 3; i++) begin
            chk(0, 5, "t2_cnt5", 2'b00, 2'b00, 0, 0, 4'd1);
            chk(0, 6, "t2_cnt6", 2'b01, 2'b00, 0, 0, 4'd1);
            chk(0, 8, "t2_cnt8", 2'b01, 2'b00, 0, 0, 4'd1);
            wait_n(8);
            hb = 2'b01;
            chk(0, 1, "t2_kick", 2'b00, 2'b00, 0, 0, 4'd1);
            wait_n(1);
            hb = 2'b00;
        end
        chk(0, 9, "t2_cnt9", 2'b01, 2'b00, 0, 0, 4'd1);
        wait_n(9);
        hb = 2'b01;
        chk(0, 1, "t2_kick_at_10", 2'b00, 2'b00, 0, 0, 4'd1);
        wait_n(1);
        hb = 2'b00;
        en = 2'b00;
        chk(0, 1, "t2_disable", 2'b00, 2'b00, 0, 0, 4'd1);
        wait_n(1);

        // 3: both channels silent from the same edge
        en = 2'b11;
        chk(0, 10, "t3_pre_trip",  2'b11, 2'b00, 0, 0, 4'd1);
        chk(0, 11, "t3_both_trip", 2'b11, 2'b11, 1, 0, 4'd2);
        wait_n(11);
        ack = 2'b11;
        chk(0, 1, "t3_ack_both", 2'b00, 2'b00, 0, 0, 4'd2);
        wait_n(1);
        ack = 2'b00;

        // 4: channel 1 forced first, channel 0 times out later
        ft = 2'b10;
        chk(0, 1, "t4_force1", 2'b10, 2'b10, 1, 1, 4'd3);
        wait_n(1);
        ft = 2'b00;
        hb = 2'b10;
        chk(0, 3, "t4_hb_ignored", 2'b10, 2'b10, 1, 1, 4'd3);
        chk(0, 5, "t4_ch0_warn",   2'b11, 2'b10, 1, 1, 4'd3);
        chk(0, 9, "t4_ch0_trip",   2'b11, 2'b11, 1, 1, 4'd4);
        wait_n(3);
        hb = 2'b00;
        wait_n(6);
        ack = 2'b10; ft = 2'b10;
        chk(0, 1, "t4_ack_and_force", 2'b11, 2'b11, 1, 1, 4'd4);
        wait_n(1);
        ft = 2'b00;
        chk(0, 1, "t4_ack1_keep_id", 2'b01, 2'b01, 1, 1, 4'd4);
        wait_n(1);
        ack = 2'b01;
        chk(0, 1, "t4_ack0_clear", 2'b00, 2'b00, 0, 0, 4'd4);
        wait_n(1);
        ack = 2'b00;
        en = 2'b00;
        chk(0, 1, "t4_disable", 2'b00, 2'b00, 0, 0, 4'd4);
        wait_n(1);

        // 5: auto-clear instance, heartbeat clears a trip
        en_b = 2'b01;
        chk(1, 11, "t5_trip", 2'b01, 2'b01, 1, 0, 4'd1);
        wait_n(11);
        hb_b = 2'b01;
        chk(1, 1, "t5_hb_clear", 2'b00, 2'b00, 0, 0, 4'd1);
        wait_n(1);
        hb_b = 2'b00;
        chk(1, 9,  "t5_pre_retrip", 2'b01, 2'b00, 0, 0, 4'd1);
        chk(1, 10, "t5_retrip",     2'b01, 2'b01, 1, 0, 4'd2);
        wait_n(10);
        en_b = 2'b00;
        chk(1, 1, "t5_disable", 2'b00, 2'b00, 0, 0, 4'd2);
        wait_n(1);

        // 6: asynchronous reset mid-count
        en = 2'b01;
        chk(0, 8, "t6_cnt7", 2'b01, 2'b00, 0, 0, 4'd4);
        wait_n(8);
        @(posedge clk);
        #1 rst = 1'b1;
        chk_rst(0, 0, "t6_rst_mid");
        chk_rst(1, 0, "t6_rst_mid_ac");
        @(negedge clk);
        rst = 1'b0;
        en = 2'b00;
        wait_n(1);

        // 6: enable drop while tripped
        en = 2'b01;
        wait_n(1);
        ft = 2'b01;
        chk(0, 1, "t6_force0", 2'b01, 2'b01, 1, 0, 4'd1);
        wait_n(1);
        ft = 2'b00;
        en = 2'b00;
        chk(0, 1, "t6_enable_drop", 2'b00, 2'b00, 0, 0, 4'd1);
        wait_n(1);

        // 6: 20 forced trips saturate the counter
        en = 2'b01;
        wait_n(1);
        for (int i = 0; i < 20; i++) begin
            ft = 2'b01; ack = 2'b00;
            chk(0, 1, "t6_sat_trip", 2'b01, 2'b01, 1, 0, 4'((i + 2 > 15) ? 15 : i + 2));
            wait_n(1);
            ft = 2'b00; ack = 2'b01;
            chk(0, 1, "t6_sat_ack", 2'b00, 2'b00, 0, 0, 4'((i + 2 > 15) ? 15 : i + 2));
            wait_n(1);
        end
        ack = 2'b00;
        en = 2'b00;
        wait_n(3);

        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb_q.size());
            miscompares += sb_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
